// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC and talks to instruction memory
// through a request/valid handshake. It holds the fetched word while the core
// executes it and computes the next PC on retire. Misaligned targets and
// memory timeouts park the unit in a sticky trap until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic        jalr,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [7:0]  WAIT_LAST    = 8'(TIMEOUT - 1);
    localparam logic [1:0]  CAUSE_NONE   = 2'b00;
    localparam logic [1:0]  CAUSE_MISAL  = 2'b01;
    localparam logic [1:0]  CAUSE_TMOUT  = 2'b10;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;
    logic        r_trap;
    logic [1:0]  r_trap_cause;
    logic [7:0]  r_wait_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;

    // Next-PC selection: jalr target wins over branch/jal, else sequential.
    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
        w_next_pc  = w_pc_plus4;
        if (jalr) begin
            w_next_pc = {ALUResult[31:1], 1'b0};
        end else if (PCSrc) begin
            w_next_pc = r_pc + ImmExt;
        end else begin
            w_next_pc = w_pc_plus4;
        end
    end

    // Fetch/execute/trap sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_trap        <= 1'b0;
            r_trap_cause  <= CAUSE_NONE;
            r_wait_cnt    <= 8'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_imem_req) begin
                        // First cycle after reset: raise the request, no
                        // response can be outstanding yet.
                        r_imem_req <= 1'b1;
                    end else if (imem_valid) begin
                        // A response on the timeout cycle still wins.
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_wait_cnt    <= 8'd0;
                        r_state       <= S_EXEC;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_imem_req   <= 1'b0;
                        r_trap       <= 1'b1;
                        r_trap_cause <= CAUSE_TMOUT;
                        r_state      <= S_TRAP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (retire) begin
                        // PC updates even for a bad target so it is visible.
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_wait_cnt    <= 8'd0;
                        if (w_next_pc[1:0] == 2'b00) begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_imem_req   <= 1'b0;
                            r_trap       <= 1'b1;
                            r_trap_cause <= CAUSE_MISAL;
                            r_state      <= S_TRAP;
                        end
                    end else begin
                        r_imem_req <= 1'b0;
                    end
                end
                S_TRAP: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_trap        <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: stop fetching and flag a trap.
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_trap        <= 1'b1;
                    r_state       <= S_TRAP;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign Instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign trap        = r_trap;
    assign trap_cause  = r_trap_cause;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage of the RISC-V core. Sits directly upstream of the controller.
- Owns the PC register and issues instruction-memory requests through a valid handshake.
- Holds the fetched instruction stable while the controller and datapath decode and execute it.
- On retire, computes the next PC from the controller's PCSrc/jalr decisions. Traps on misaligned targets and on memory timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT, 16, maximum wait cycles for imem_valid before a fetch fault; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- PCSrc  in  1  from controller; take pc+ImmExt (branch taken or jal).
- jalr  in  1  from controller; take the jalr target, which has priority over PCSrc.
- ImmExt  in  32  sign-extended immediate of the current instruction.
- ALUResult  in  32  rs1+imm for jalr.
- retire  in  1  one-cycle pulse from core: the current instruction has completed.
- imem_req  out  1  fetch request strobe.
- imem_addr  out  32  fetch address (equals pc).
- imem_rdata  in  32  instruction word, sampled when imem_valid=1.
- imem_valid  in  1  memory response valid.
- Instr  out  32  registered instruction to the controller and decoder.
- instr_valid  out  1  Instr is valid and executing.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4 for the ResultSrc link path.
- trap  out  1  sticky fault indicator.
- trap_cause  out  2  2'b01 misaligned target, 2'b10 fetch timeout, 2'b00 none.

Behaviour:
- Reset values:
  - pc=RESET_PC, Instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0.
  - trap=0, trap_cause=0, wait counter=0, state=FETCH.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On the same cycle, imem_valid=1 captures imem_rdata into Instr and goes to EXEC. Otherwise the wait counter increments.
  - EXEC: instr_valid=1, imem_req=0, Instr and pc stable. On retire=1, pc<=next_pc.
    - If next_pc[1:0]==0, go to FETCH and clear the wait counter.
    - Otherwise go to TRAP with cause 01. pc still updates so the bad target is visible.
  - TRAP: all requests stop, instr_valid=0, trap=1, trap_cause held. Exit only by reset.
- Fetch timeout: in FETCH with no imem_valid, the counter reaching TIMEOUT-1 means the next cycle enters TRAP with cause 10. imem_valid on the timeout cycle itself wins and goes to EXEC.
- Fetch latency: minimum 1 cycle from entering FETCH to instr_valid (zero-wait memory). Back-to-back instructions take ≥2 cycles each.
- next_pc (32-bit, wrap modulo 2^32, no overflow detection):
  - If jalr=1: {ALUResult[31:1],1'b0}.
  - Else if PCSrc=1: pc+ImmExt.
  - Else: pc+4.
- pc_plus4 = pc+4 combinationally, always driven, including in TRAP.
- Ignored inputs:
  - retire is ignored outside EXEC.
  - imem_valid is ignored outside FETCH (spurious response, no state change).
  - PCSrc, jalr, ImmExt and ALUResult are only sampled on a retire in EXEC.
- Reset mid-operation: reset wins over every other event in the same cycle, including imem_valid and retire. After the reset edge the block is in FETCH with pc=RESET_PC, and the first request is on the following cycle.
- No new request is issued while instr_valid=1. There is a single outstanding request at most.

Test Plan:
- Reset with RESET_PC=0 → cycle after reset: imem_req=1, imem_addr=0. Drive imem_valid with rdata=0x00500093 → next cycle instr_valid=1, Instr=0x00500093, pc=0.
- Sequential: retire with PCSrc=0, jalr=0 at pc=0x10 → pc=0x14, FETCH with imem_addr=0x14, pc_plus4=0x18.
- Branch/jal and jalr:
  - pc=0x100, PCSrc=1, ImmExt=0xFFFFFFF8 → pc=0xF8.
  - jalr=1 with PCSrc=1 and ALUResult=0x205 → pc=0x204 (jalr priority, bit0 cleared).
- Misaligned: PCSrc=1, ImmExt=0x2 at pc=0x40 → pc=0x42, trap=1, trap_cause=01, imem_req stays 0 for 20 cycles. Then reset → pc=0, trap=0.
- Timeout with TIMEOUT=4:
  - Hold imem_valid=0 in FETCH → TRAP with cause 10 after 4 wait cycles.
  - Repeat with imem_valid on the 4th cycle → EXEC, no trap.
- Collisions and spurious inputs:
  - imem_valid and reset in the same cycle → Instr stays nop, pc=RESET_PC.
  - Spurious imem_valid in EXEC → Instr unchanged.
  - retire in FETCH → ignored.
